// File: rtl/amo_unit.sv
// amo_unit: runs LR/SC/AMO requests as plain memory read/write sequences; other accesses pass straight through.
module amo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        slave_valid,
  output logic        slave_ready,
  input  logic [63:0] slave_addr,
  input  logic        slave_wen,
  input  logic [63:0] slave_wdata,
  input  logic [7:0]  slave_wmask,
  input  logic        slave_is_amo,
  input  logic [4:0]  slave_amoop,
  input  logic        slave_aq,
  input  logic        slave_rl,
  input  logic [2:0]  slave_funct3,
  output logic        slave_rvalid,
  output logic [63:0] slave_rdata,
  output logic        master_valid,
  input  logic        master_ready,
  output logic [63:0] master_addr,
  output logic        master_wen,
  output logic [63:0] master_wdata,
  output logic [7:0]  master_wmask,
  output logic        master_is_amo,
  output logic [4:0]  master_amoop,
  output logic        master_aq,
  output logic        master_rl,
  output logic [2:0]  master_funct3,
  input  logic        master_rvalid,
  input  logic [63:0] master_rdata
);
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;
  typedef enum logic [2:0] {INIT, AMO_READ_REQ, AMO_READ_WAIT, AMO_WRITE_REQ, AMO_WRITE_WAIT, SC_FAIL} state_t;
  state_t      state;
  logic        rsv_valid;
  logic [60:0] rsv_addr;
  logic [63:0] addr_q, wdata_q, old_q, new_q;
  logic [7:0]  wmask_q;
  logic [4:0]  amoop_q;
  logic        aq_q, rl_q;
  logic [2:0]  funct3_q;
  logic        in_init, is_lr, is_sc, word, rsv_hit;
  logic [31:0] lane_a, lane_b;
  logic [63:0] a, b, r, new_val, sc_fail_data;
  logic        eq, lt_s, lt_u;
  assign in_init = state == INIT;
  assign is_lr   = amoop_q == OP_LR;
  assign is_sc   = amoop_q == OP_SC;
  assign word    = funct3_q[1:0] == 2'b10;
  assign rsv_hit = rsv_valid && rsv_addr == slave_addr[63:3];
  // Word ops are sign-extended so one 64-bit comparator serves both widths
  assign lane_a  = addr_q[2] ? master_rdata[63:32] : master_rdata[31:0];
  assign lane_b  = addr_q[2] ? wdata_q[63:32] : wdata_q[31:0];
  assign a       = word ? {{32{lane_a[31]}}, lane_a} : master_rdata;
  assign b       = word ? {{32{lane_b[31]}}, lane_b} : wdata_q;
  assign eq      = a == b;
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;
  assign r = amoop_q == OP_SWAP ? b :
             amoop_q == OP_ADD  ? a + b :
             amoop_q == OP_XOR  ? a ^ b :
             amoop_q == OP_AND  ? a & b :
             amoop_q == OP_OR   ? a | b :
             amoop_q == OP_MIN  ? ((lt_s || eq) ? a : b) :
             amoop_q == OP_MAX  ? (lt_s ? b : a) :
             amoop_q == OP_MINU ? ((lt_u || eq) ? a : b) :
             amoop_q == OP_MAXU ? (lt_u ? b : a) : a;
  assign new_val      = word ? {r[31:0], r[31:0]} : r;
  assign sc_fail_data = (word && addr_q[2]) ? 64'h0000_0001_0000_0000 : 64'd1;
  assign slave_ready  = in_init && (slave_is_amo || master_ready);
  assign slave_rvalid = in_init ? master_rvalid :
                        (state == SC_FAIL) || (master_rvalid && (state == AMO_WRITE_WAIT || (state == AMO_READ_WAIT && is_lr)));
  assign slave_rdata  = (in_init || state == AMO_READ_WAIT) ? master_rdata :
                        state == AMO_WRITE_WAIT ? (is_sc ? 64'd0 : old_q) : sc_fail_data;
  assign master_valid  = in_init ? (slave_valid && !slave_is_amo) : (state == AMO_READ_REQ || state == AMO_WRITE_REQ);
  assign master_addr   = in_init ? slave_addr : addr_q;
  assign master_wen    = in_init ? slave_wen : state == AMO_WRITE_REQ;
  assign master_wdata  = in_init ? slave_wdata : (is_sc ? wdata_q : new_q);
  assign master_wmask  = in_init ? slave_wmask : wmask_q;
  assign master_is_amo = 1'b0;
  assign master_amoop  = in_init ? slave_amoop : amoop_q;
  assign master_aq     = in_init ? slave_aq : aq_q;
  assign master_rl     = in_init ? slave_rl : rl_q;
  assign master_funct3 = in_init ? slave_funct3 : funct3_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      rsv_valid <= 1'b0;
      rsv_addr  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      amoop_q   <= '0;
      aq_q      <= 1'b0;
      rl_q      <= 1'b0;
      funct3_q  <= '0;
      old_q     <= '0;
      new_q     <= '0;
    end else begin
      case (state)
        INIT: begin
          if (slave_valid && slave_is_amo) begin
            addr_q   <= slave_addr;
            wdata_q  <= slave_wdata;
            wmask_q  <= slave_wmask;
            amoop_q  <= slave_amoop;
            aq_q     <= slave_aq;
            rl_q     <= slave_rl;
            funct3_q <= slave_funct3;
            if (slave_amoop == OP_SC) rsv_valid <= 1'b0;
            state <= slave_amoop != OP_SC ? AMO_READ_REQ : rsv_hit ? AMO_WRITE_REQ : SC_FAIL;
          end else if (slave_valid && master_ready && slave_wen && rsv_hit) begin
            rsv_valid <= 1'b0;
          end
        end
        AMO_READ_REQ: if (master_ready) state <= AMO_READ_WAIT;
        AMO_READ_WAIT: begin
          if (master_rvalid && is_lr) begin
            rsv_valid <= 1'b1;
            rsv_addr  <= addr_q[63:3];
            state     <= INIT;
          end else if (master_rvalid) begin
            old_q <= master_rdata;
            new_q <= new_val;
            state <= AMO_WRITE_REQ;
          end
        end
        AMO_WRITE_REQ: if (master_ready) state <= AMO_WRITE_WAIT;
        AMO_WRITE_WAIT: if (master_rvalid) state <= INIT;
        default: state <= INIT;
      endcase
    end
  end
endmodule
